// File: rtl/instr_encode.sv
// RV32 immediate encoder: packs a signed offset into I/S/B/J instruction fields and flags out-of-range values.
// One-cycle latency through a single output register; in_ready drops only while a result is stalled by out_ready.
module instr_encode #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       imm_sel,
  input  logic [31:0]      imm,
  input  logic [31:0]      base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             range_err,
  output logic             err_sticky,
  input  logic             err_clr,
  output logic [CNT_W-1:0] enc_count
);

  localparam logic [1:0] SEL_I = 2'b00;
  localparam logic [1:0] SEL_S = 2'b01;
  localparam logic [1:0] SEL_B = 2'b10;
  localparam logic [1:0] SEL_J = 2'b11;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic             range_err_q, range_err_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] enc_count_q, enc_count_d;

  logic [31:0] enc;
  logic        enc_err;
  logic        accept;
  logic        xfer;

  // Out of range when the bits above the field's sign bit are not a pure sign extension.
  always_comb begin
    enc     = base;
    enc_err = 1'b0;
    unique case (imm_sel)
      SEL_I: begin
        enc     = {imm[11:0], base[19:0]};
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_S: begin
        enc     = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
        enc_err = !((&imm[31:11]) || !(|imm[31:11]));
      end
      SEL_B: begin
        enc     = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
        enc_err = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      end
      SEL_J: begin
        enc     = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        enc_err = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    instr_d      = instr_q;
    range_err_d  = range_err_q;
    err_sticky_d = err_sticky_q;
    enc_count_d  = enc_count_q;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc;
      range_err_d = enc_err;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (xfer && (enc_count_q != {CNT_W{1'b1}})) begin
      enc_count_d = enc_count_q + CNT_W'(1);
    end
    // A set in the same cycle as a clear takes priority.
    if (xfer && range_err_q) begin
      err_sticky_d = 1'b1;
    end else if (err_clr) begin
      err_sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      instr_q      <= 32'h0;
      range_err_q  <= 1'b0;
      err_sticky_q <= 1'b0;
      enc_count_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      instr_q      <= instr_d;
      range_err_q  <= range_err_d;
      err_sticky_q <= err_sticky_d;
      enc_count_q  <= enc_count_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign instr      = instr_q;
  assign range_err  = range_err_q;
  assign err_sticky = err_sticky_q;
  assign enc_count  = enc_count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Scoreboard bench for instr_encode: expected results are queued at accept and compared at output transfer.
module tb_instr_encode;

  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    imm_sel;
  logic [31:0]   imm;
  logic [31:0]   base;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   instr;
  logic          range_err;
  logic          err_sticky;
  logic          err_clr;
  logic [CW-1:0] enc_count;

  instr_encode #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_sel   (imm_sel),
    .imm       (imm),
    .base      (base),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr     (instr),
    .range_err (range_err),
    .err_sticky(err_sticky),
    .err_clr   (err_clr),
    .enc_count (enc_count)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   exp_cnt = 0;
  logic rnd_rdy = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, expv);
  endtask

  // Independent bit-by-bit packing with arithmetic range bounds.
  function automatic exp_t model(input logic [1:0] s, input logic [31:0] im, input logic [31:0] b);
    exp_t e;
    int   si;
    si = im;
    e.sel = s; e.imm = im; e.instr = b; e.err = 1'b0;
    case (s)
      2'b00: begin
        for (int i = 0; i < 12; i++) e.instr[20+i] = im[i];
        e.err = (si < -2048) || (si > 2047);
      end
      2'b01: begin
        for (int i = 0; i < 5; i++) e.instr[7+i] = im[i];
        for (int i = 5; i < 12; i++) e.instr[20+i] = im[i];
        e.err = (si < -2048) || (si > 2047);
      end
      2'b10: begin
        e.instr[31] = im[12];
        e.instr[7]  = im[11];
        for (int i = 5; i < 11; i++) e.instr[20+i] = im[i];
        for (int i = 1; i < 5; i++) e.instr[7+i] = im[i];
        e.err = (si < -4096) || (si > 4095) || im[0];
      end
      default: begin
        e.instr[31] = im[20];
        for (int i = 12; i < 20; i++) e.instr[i] = im[i];
        e.instr[20] = im[11];
        for (int i = 1; i < 11; i++) e.instr[20+i] = im[i];
        e.err = (si < -1048576) || (si > 1048575) || im[0];
      end
    endcase
    return e;
  endfunction

  function automatic logic [31:0] dec(input logic [1:0] s, input logic [31:0] w);
    case (s)
      2'b00:   return {{20{w[31]}}, w[31:20]};
      2'b01:   return {{20{w[31]}}, w[31:25], w[11:7]};
      2'b10:   return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      default: return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endcase
  endfunction

  function automatic exp_t mk(input logic [1:0] s, input logic [31:0] im, input logic [31:0] ins, input logic er);
    exp_t e;
    e.sel = s; e.imm = im; e.instr = ins; e.err = er;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 of the accepting edge with in_valid still high.
  task automatic send(input logic [1:0] s, input logic [31:0] im, input logic [31:0] b, input exp_t e);
    logic got;
    got = 1'b0;
    imm_sel = s; imm = im; base = b; in_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(e);
        got = 1'b1;
      end
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    logic done;
    done = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #1;
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) check("drain_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("instr", instr, e.instr);
        check("range_err", {31'd0, range_err}, {31'd0, e.err});
        if (!e.err) check("roundtrip", dec(e.sel, instr), e.imm);
      end
      if (exp_cnt < (1 << CW) - 1) exp_cnt++;
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    int        cnt0;
    exp_t      e;
    logic [1:0]  s;
    logic [31:0] r, im;
    int        w;
    rst_n = 1'b0; in_valid = 1'b0; imm_sel = 2'b00; imm = 32'h0; base = 32'h0;
    out_ready = 1'b0; err_clr = 1'b0;
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_err", {31'd0, range_err}, 32'd0);
    check("rst_sticky", {31'd0, err_sticky}, 32'd0);
    check("rst_count", {28'd0, enc_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Reference vectors, back to back
    out_ready = 1'b1;
    send(2'b00, 32'd5, 32'h00000113, mk(2'b00, 32'd5, 32'h00500113, 1'b0));
    check("latency_vld", {31'd0, out_valid}, 32'd1);
    check("latency_instr", instr, 32'h00500113);
    send(2'b01, 32'hFFFFFFFC, 32'h00512023, mk(2'b01, 32'hFFFFFFFC, 32'hFE512E23, 1'b0));
    send(2'b10, 32'd8, 32'h00000063, mk(2'b10, 32'd8, 32'h00000463, 1'b0));
    send(2'b11, 32'hFFFFFFFC, 32'h000000EF, mk(2'b11, 32'hFFFFFFFC, 32'hFFDFF0EF, 1'b0));
    drain();
    check("sticky_clean", {31'd0, err_sticky}, 32'd0);

    // Range errors, sticky flag and clear priority
    send(2'b00, 32'h800, 32'h00000113, mk(2'b00, 32'h800, 32'h80000113, 1'b1));
    idle(1);
    check("sticky_set", {31'd0, err_sticky}, 32'd1);
    err_clr = 1'b1; idle(1); err_clr = 1'b0;
    check("sticky_clr", {31'd0, err_sticky}, 32'd0);
    err_clr = 1'b1;
    send(2'b10, 32'd3, 32'h00000063, mk(2'b10, 32'd3, 32'h00000163, 1'b1));
    idle(1);
    check("sticky_set_wins", {31'd0, err_sticky}, 32'd1);
    idle(1); err_clr = 1'b0;
    check("sticky_clr2", {31'd0, err_sticky}, 32'd0);
    drain();

    // Backpressure
    cnt0 = exp_cnt;
    out_ready = 1'b0;
    send(2'b00, 32'd1, 32'h00000013, mk(2'b00, 32'd1, 32'h00100013, 1'b0));
    imm_sel = 2'b00; imm = 32'd2; base = 32'h00000013; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_instr", instr, 32'h00100013);
    end
    out_ready = 1'b1;
    send(2'b00, 32'd2, 32'h00000013, mk(2'b00, 32'd2, 32'h00200013, 1'b0));
    check("bp_b2b_valid", {31'd0, out_valid}, 32'd1);
    drain();
    check("bp_count", {28'd0, enc_count}, 32'(cnt0 + 2));
    check("count_model", {28'd0, enc_count}, 32'(exp_cnt));

    // Reset while a result is stalled
    send(2'b10, 32'd3, 32'h00000063, mk(2'b10, 32'd3, 32'h00000163, 1'b1));
    idle(1);
    out_ready = 1'b0;
    send(2'b00, 32'd7, 32'h00000013, mk(2'b00, 32'd7, 32'h00700013, 1'b0));
    in_valid = 1'b0;
    check("pre_rst_sticky", {31'd0, err_sticky}, 32'd1);
    check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_instr", instr, 32'd0);
    check("mid_rst_sticky", {31'd0, err_sticky}, 32'd0);
    check("mid_rst_count", {28'd0, enc_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    imm_sel = 2'b01; imm = 32'hFFFFFFFC; base = 32'h00512023; in_valid = 1'b1;
    exp_q.push_back(mk(2'b01, 32'hFFFFFFFC, 32'hFE512E23, 1'b0));
    @(posedge clk); #1;
    check("first_accept", {31'd0, out_valid}, 32'd1);
    drain();
    check("post_rst_count", {28'd0, enc_count}, 32'd1);

    // Randomised traffic with random backpressure
    rnd_rdy = 1'b1;
    for (int n = 0; n < 40; n++) begin
      s = 2'($urandom_range(0, 3));
      r = $urandom;
      w = (s == 2'b11) ? 21 : (s == 2'b10) ? 13 : 12;
      case ($urandom_range(0, 3))
        0: im = r;
        1: begin im = $signed(r << (32 - w)) >>> (32 - w); if (s[1]) im[0] = 1'b0; end
        2: im = $signed(r << (32 - w)) >>> (32 - w);
        default: begin
          im = 32'd1 << (w - 1);
          if (r[0]) im = ~im + 32'd1;
          if (r[1]) im = im - 32'd1;
          if (s[1]) im[0] = 1'b0;
        end
      endcase
      e = model(s, im, $urandom);
      send(s, im, e.instr ^ {32{1'b0}}, e);
      idle($urandom_range(0, 2));
    end
    rnd_rdy = 1'b0;
    #1 out_ready = 1'b1;
    drain();
    check("rand_count", {28'd0, enc_count}, 32'(exp_cnt));
    check("count_saturated", {28'd0, enc_count}, 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_encode.md
INSTR_ENCODE -- requirements
Module: instr_encode

Interface
REQ-001 Parameter CNT_W, default 16, width of the accepted-instruction counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  request carries a valid imm/imm_sel/base triple.
REQ-005 in_ready  output  1  block can accept a request this cycle.
REQ-006 imm_sel  input  2  format: 00 I-type (load/ALU-imm), 01 S-type (store), 10 B-type (branch), 11 J-type (jump).
REQ-007 imm  input  32  signed byte-offset or immediate value to be encoded.
REQ-008 base  input  32  instruction with opcode/register/funct fields; bits at the selected format's immediate positions are don't-care.
REQ-009 out_valid  output  1  instr/range_err hold a valid encoded result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 instr  output  32  encoded instruction.
REQ-012 range_err  output  1  imm not representable in the selected format; qualified by out_valid.
REQ-013 err_sticky  output  1  latched OR of every accepted range_err.
REQ-014 err_clr  input  1  synchronous clear of err_sticky.
REQ-015 enc_count  output  CNT_W  number of results accepted at the output.

Function
REQ-016 Accept occurs on in_valid && in_ready; output transfer occurs on out_valid && out_ready.
REQ-017 in_ready SHALL equal !out_valid || out_ready, giving a one-entry output register with full throughput.
REQ-018 Latency SHALL be one cycle: a request accepted at edge N is presented with out_valid=1 after edge N.
REQ-019 While out_valid && !out_ready, instr, range_err and out_valid SHALL hold stable.
REQ-020 out_valid clears after a transfer with no simultaneous accept; a simultaneous transfer and accept loads the new result and keeps out_valid=1.
REQ-021 I: instr[31:20]=imm[11:0]; all other bits from base.
REQ-022 S: instr[31:25]=imm[11:5], instr[11:7]=imm[4:0]; all other bits from base.
REQ-023 B: instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]; all other bits from base.
REQ-024 J: instr[31]=imm[20], instr[19:12]=imm[19:12], instr[20]=imm[11], instr[30:21]=imm[10:1]; all other bits from base.
REQ-025 range_err for I/S: imm[31:11] not all equal.
REQ-026 range_err for B: imm[31:12] not all equal, or imm[0]=1.
REQ-027 range_err for J: imm[31:20] not all equal, or imm[0]=1.
REQ-028 When range_err=1, instr is still packed from the truncated imm bits per REQ-021..024.
REQ-029 Round-trip: when range_err=0, sign-extending instr's immediate for the same imm_sel SHALL reproduce imm exactly.
REQ-030 enc_count increments by 1 on each output transfer and saturates at all-ones.
REQ-031 err_sticky sets on an output transfer with range_err=1; err_clr clears it; if both occur in the same cycle, set wins.

Reset
REQ-032 rst_n low SHALL immediately force out_valid=0, instr=0, range_err=0, err_sticky=0 and enc_count=0, independent of clk.
REQ-033 During reset in_ready SHALL be 1; a result pending when reset asserts SHALL be discarded and not counted.
REQ-034 After rst_n deasserts, the first accept is allowed on the first subsequent rising edge.

Verification
REQ-035 I: base=0x00000113, imm=5, sel=00 -> instr=0x00500113, range_err=0, out_valid=1 one cycle after accept.
REQ-036 S: base=0x00512023, imm=0xFFFFFFFC, sel=01 -> instr=0xFE512E23; B: base=0x00000063, imm=8, sel=10 -> instr=0x00000463.
REQ-037 J: base=0x000000EF, imm=0xFFFFFFFC, sel=11 -> instr=0xFFDFF0EF, range_err=0.
REQ-038 Range: I imm=0x800 -> range_err=1, err_sticky=1, instr=0x80000113; B imm=3 -> range_err=1; err_clr pulse clears err_sticky.
REQ-039 Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> instr stable, in_ready=0, no second accept; release -> back-to-back results, enc_count +2.
REQ-040 Reset mid-operation: assert rst_n=0 while out_valid=1 and out_ready=0 -> outputs zero immediately, enc_count=0, pending result not delivered.
